load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits directly upstream of the word-addressed data memory and is the only master on the memory's rd_en/wr_en/addr/data port.
- Turns core byte, halfword and word load/store requests into 32-bit word accesses.
- Sub-word stores use read-modify-write. Loads return the extracted lane, sign- or zero-extended.
- Memory read data is combinational from address; writes commit on posedge clk. ack from the memory is not used; timing is fixed by this FSM.

Parameters:
- MEM_SIZE_WORDS, 4096, number of 32-bit words in the attached memory. Byte addresses at or above 4*MEM_SIZE_WORDS are errors.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- req_i  input  1  request strobe; sampled only in IDLE
- we_i  input  1  1 = store, 0 = load
- funct3_i  input  3  RISC-V width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr_i  input  32  byte address
- wdata_i  input  32  store data; low byte or halfword used for B/H
- rdata_o  output  32  load result; held until the next load completes
- done_o  output  1  one-cycle completion pulse
- err_o  output  1  valid with done_o: request rejected, no memory access
- busy_o  output  1  high whenever state != IDLE
- mem_rd_en_o  output  1  to memory rd_en
- mem_wr_en_o  output  1  to memory wr_en
- mem_addr_o  output  32  word-aligned address, {addr[31:2],2'b00}
- mem_wdata_o  output  32  word to write
- mem_rdata_i  input  32  combinational read data from memory

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=IDLE; rdata_o=0; done_o=0; err_o=0.
  - mem_wr_en_o is ANDed combinationally with rst_n, so no write commits on a reset edge, even mid-operation.
- IDLE:
  - On req_i=1, latch we, funct3, addr and wdata.
  - req_i while busy is ignored; it is neither queued nor acknowledged.
- Error check at accept:
  - funct3 not in {000,001,010,100,101} is an error.
  - we=1 with funct3 100/101 is an error.
  - H/HU with addr[0]=1 is an error.
  - W with addr[1:0]!=0 is an error.
  - addr >= 4*MEM_SIZE_WORDS is an error.
  - Any error -> state ERR.
- Otherwise the next state is:
  - Load -> READ
  - SW -> WRITE
  - SB/SH -> READ
- READ:
  - mem_rd_en_o=1.
  - Load: at the edge, extract the lane selected by addr[1:0] (B) or addr[1] (H), extend it, register into rdata_o, go to DONE.
  - SB/SH: register mem_rdata_i into the merge buffer, go to WRITE.
- WRITE:
  - mem_wr_en_o=1.
  - mem_wdata_o = wdata (SW), or the merge buffer with the target byte/halfword lane replaced.
  - Go to DONE.
- DONE: done_o=1, err_o=0, then IDLE.
- ERR: done_o=1, err_o=1, then IDLE. rdata_o unchanged; no mem enable is ever asserted.
- Outside READ/WRITE: mem_rd_en_o=mem_wr_en_o=0, mem_wdata_o=0.
- Latency (req edge to done_o high):
  - Loads: 2 cycles.
  - SW: 2 cycles.
  - SB/SH: 3 cycles.
  - Errors: 1 cycle.
- Next request may be accepted in the cycle done_o is high + 1 (IDLE). No back-to-back overlap.
- Extension:
  - LB: bit 7 of the lane is replicated to bits 31:8.
  - LH: bit 15 is replicated to bits 31:16.
  - BU/HU: zero-fill.

Decomposition:
- Package lsu_pkg holds:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - state encoding IDLE, READ, WRITE, DONE, ERR (3 bits).
- Sub-module lsu_data_align is purely combinational and takes funct3, addr[1:0], word_in and store_data. It outputs:
  - load_result: extracted and extended lane.
  - merged_word: store merge.
  - misaligned: alignment error flag.
- Top keeps the FSM, latches and the range check.

Test Plan:
- Memory word at byte address 0x10 = 0x8899AABB. LB addr 0x11 -> done_o 2 cycles after req, rdata_o=0xFFFFFFAA, err_o=0. LBU addr 0x13 -> 0x00000088.
- Same word: LH 0x12 -> 0xFFFF8899. LHU 0x10 -> 0x0000AABB. LW 0x10 -> 0x8899AABB.
- SB addr 0x12, wdata 0x12345655:
  - One READ cycle, then one WRITE with mem_wdata_o=0x8855AABB, done_o 3 cycles after req.
  - Subsequent LW 0x10 returns 0x8855AABB.
- Misaligned and illegal requests, each -> done_o+err_o next cycle, no mem_rd_en_o/mem_wr_en_o pulse, rdata_o unchanged:
  - SW 0x16.
  - LH 0x11.
  - funct3=011.
  - addr 0x4000 with MEM_SIZE_WORDS=4096.
- Reset mid-op: SH 0x20 (word 0x11223344, wdata 0xBEEF) with rst_n low during the WRITE cycle -> memory still 0x11223344, state IDLE, busy_o=0 and done_o=0 after the reset edge.
- req_i held high through a whole LW -> exactly one access and one done_o. A second request is accepted only in IDLE; req_i pulsed while busy produces no extra done_o.

Source files
------------

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : lsu_pkg
// Brief   : Shared width codes and FSM encoding for the load/store unit.
// Revision: 1.0
// ============================================================================
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WRITE = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } lsu_state_e;

    function automatic logic f3_legal(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_data_align.sv
`default_nettype none
// ============================================================================
// Module  : lsu_data_align
// Brief   : Lane extraction/extension for loads, lane merge for sub-word stores.
// Revision: 1.0
// ============================================================================
module lsu_data_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] word_in,
    input  logic [15:0] store_data,
    output logic [31:0] load_result,
    output logic [31:0] merged_word,
    output logic        misaligned
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = word_in[{addr_lo, 3'b000} +: 8];
    assign w_half = word_in[{addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        load_result = 32'd0;
        merged_word = word_in;
        misaligned  = 1'b0;
        case (funct3)
            F3_B: begin
                load_result = {{24{w_byte[7]}}, w_byte};
                merged_word[{addr_lo, 3'b000} +: 8] = store_data[7:0];
            end
            F3_BU: begin
                load_result = {24'd0, w_byte};
            end
            F3_H: begin
                load_result = {{16{w_half[15]}}, w_half};
                merged_word[{addr_lo[1], 4'b0000} +: 16] = store_data;
                misaligned  = addr_lo[0];
            end
            F3_HU: begin
                load_result = {16'd0, w_half};
                misaligned  = addr_lo[0];
            end
            F3_W: begin
                load_result = word_in;
                misaligned  = (addr_lo != 2'b00);
            end
            default: begin
                load_result = 32'd0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module  : load_store_unit
// Brief   : Byte/half/word loads and stores onto a word-addressed memory port.
// Revision: 1.0
// ============================================================================
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_SIZE_WORDS = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        done_o,
    output logic        err_o,
    output logic        busy_o,
    output logic        mem_rd_en_o,
    output logic        mem_wr_en_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i
);

    localparam logic [32:0] c_ADDR_LIMIT = 33'(MEM_SIZE_WORDS) * 33'd4;

    lsu_state_e  r_state;
    lsu_state_e  w_next_state;
    logic        r_we;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_merge;
    logic [31:0] r_rdata;

    logic [2:0]  w_align_f3;
    logic [1:0]  w_align_lo;
    logic [31:0] w_align_word;
    logic [31:0] w_load_result;
    logic [31:0] w_merged;
    logic        w_misaligned;
    logic        w_req_err;
    logic        w_wr_en;

    // One aligner serves the accept-time check (IDLE) and the data path later.
    assign w_align_f3   = (r_state == IDLE) ? funct3_i    : r_funct3;
    assign w_align_lo   = (r_state == IDLE) ? addr_i[1:0] : r_addr[1:0];
    assign w_align_word = (r_state == WRITE) ? r_merge    : mem_rdata_i;

    lsu_data_align u_align (
        .funct3      (w_align_f3),
        .addr_lo     (w_align_lo),
        .word_in     (w_align_word),
        .store_data  (r_wdata[15:0]),
        .load_result (w_load_result),
        .merged_word (w_merged),
        .misaligned  (w_misaligned)
    );

    assign w_req_err = !f3_legal(funct3_i)
                     || (we_i && ((funct3_i == F3_BU) || (funct3_i == F3_HU)))
                     || w_misaligned
                     || ({1'b0, addr_i} >= c_ADDR_LIMIT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        mem_rd_en_o  = 1'b0;
        w_wr_en      = 1'b0;
        mem_wdata_o  = 32'd0;
        done_o       = 1'b0;
        err_o        = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_i) begin
                    if (w_req_err) begin
                        w_next_state = ERR;
                    end else if (we_i && (funct3_i == F3_W)) begin
                        w_next_state = WRITE;
                    end else begin
                        w_next_state = READ;
                    end
                end
            end
            READ: begin
                mem_rd_en_o  = 1'b1;
                w_next_state = r_we ? WRITE : DONE;
            end
            WRITE: begin
                w_wr_en      = 1'b1;
                mem_wdata_o  = (r_funct3 == F3_W) ? r_wdata : w_merged;
                w_next_state = DONE;
            end
            DONE: begin
                done_o       = 1'b1;
                w_next_state = IDLE;
            end
            ERR: begin
                done_o       = 1'b1;
                err_o        = 1'b1;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Gating with rst_n keeps a reset edge landing in WRITE from committing.
    assign mem_wr_en_o = w_wr_en & rst_n;
    assign mem_addr_o  = {r_addr[31:2], 2'b00};
    assign busy_o      = (r_state != IDLE);
    assign rdata_o     = r_rdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_we     <= 1'b0;
            r_funct3 <= 3'd0;
            r_addr   <= 32'd0;
            r_wdata  <= 32'd0;
            r_merge  <= 32'd0;
            r_rdata  <= 32'd0;
        end else begin
            if ((r_state == IDLE) && req_i) begin
                r_we     <= we_i;
                r_funct3 <= funct3_i;
                r_addr   <= addr_i;
                r_wdata  <= wdata_i;
            end
            if (r_state == READ) begin
                if (r_we) begin
                    r_merge <= mem_rdata_i;
                end else begin
                    r_rdata <= w_load_result;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_load_store_unit
// Brief   : Directed scoreboard bench for load_store_unit with a memory model.
// Revision: 1.0
// ============================================================================
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        req_i;
    logic        we_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic        done_o;
    logic        err_o;
    logic        busy_o;
    logic        mem_rd_en_o;
    logic        mem_wr_en_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;

    load_store_unit #(.MEM_SIZE_WORDS(4096)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req_i),
        .we_i        (we_i),
        .funct3_i    (funct3_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .rdata_o     (rdata_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .busy_o      (busy_o),
        .mem_rd_en_o (mem_rd_en_o),
        .mem_wr_en_o (mem_wr_en_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i)
    );

    logic [31:0] mem [0:4095];
    assign mem_rdata_i = mem[mem_addr_o[13:2]];
    always @(posedge clk) begin
        if (mem_wr_en_o) mem[mem_addr_o[13:2]] <= mem_wdata_o;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          issue;
        int          lat;
    } exp_t;
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    exp_t exp_q[$];
    wr_t  wr_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   rd_cnt   = 0;
    int   wr_cnt   = 0;
    logic [31:0] last_r;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expectations whenever the DUT completes or writes memory.
    exp_t e;
    wr_t  w;
    always @(negedge clk) begin
        if (rst_n && done_o) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done_o=1 expected no completion (t=%0t)", $time);
            end else begin
                e = exp_q.pop_front();
                check32("done_err", {31'd0, err_o}, {31'd0, e.err});
                check32("done_rdata", rdata_o, e.rdata);
                check32("done_latency", 32'(cyc - e.issue), 32'(e.lat));
            end
        end
        if (mem_wr_en_o) begin
            if (wr_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got wr to 0x%08h expected none", mem_addr_o);
            end else begin
                w = wr_q.pop_front();
                check32("wr_addr", mem_addr_o, w.addr);
                check32("wr_data", mem_wdata_o, w.data);
            end
        end
        if (mem_rd_en_o) rd_cnt++;
        if (mem_wr_en_o) wr_cnt++;
    end

    task automatic do_op(input string name, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_r, input logic exp_err, input int lat,
                         input int exp_rd, input int exp_wr, input bit hold, input bit pulse);
        int  rd0, wr0;
        bit  seen;
        @(negedge clk);
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        req_i = 1'b1; we_i = we; funct3_i = f3; addr_i = addr; wdata_i = wd;
        exp_q.push_back('{rdata: exp_r, err: exp_err, issue: cyc, lat: lat});
        @(negedge clk);
        if (!hold) req_i = 1'b0;
        if (pulse) begin
            req_i = 1'b1; we_i = 1'b0; funct3_i = F3_W; addr_i = 32'h4;
            @(negedge clk);
            req_i = 1'b0;
        end
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            if (done_o) seen = 1'b1;
            else @(negedge clk);
        end
        req_i = 1'b0;
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: got no done_o expected done within 8 cycles", name);
        end
        repeat (3) @(negedge clk);
        check32({name, "_rd_count"}, 32'(rd_cnt - rd0), 32'(exp_rd));
        check32({name, "_wr_count"}, 32'(wr_cnt - wr0), 32'(exp_wr));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req_i = 1'b0; we_i = 1'b0; funct3_i = 3'd0;
        addr_i = 32'd0; wdata_i = 32'd0;
        for (int i = 0; i < 4096; i++) mem[i] = 32'd0;
        mem[4] = 32'h8899AABB;
        mem[8] = 32'h11223344;
        repeat (3) @(negedge clk);
        check32("rst_rdata", rdata_o, 32'd0);
        check32("rst_done", {31'd0, done_o}, 32'd0);
        check32("rst_err", {31'd0, err_o}, 32'd0);
        check32("rst_busy", {31'd0, busy_o}, 32'd0);
        rst_n = 1'b1;

        // Loads on 0x8899AABB
        do_op("lb",  0, F3_B,  32'h11, 0, 32'hFFFFFFAA, 0, 2, 1, 0, 0, 0);
        do_op("lbu", 0, F3_BU, 32'h13, 0, 32'h00000088, 0, 2, 1, 0, 0, 0);
        do_op("lh",  0, F3_H,  32'h12, 0, 32'hFFFF8899, 0, 2, 1, 0, 0, 0);
        do_op("lhu", 0, F3_HU, 32'h10, 0, 32'h0000AABB, 0, 2, 1, 0, 0, 0);
        do_op("lw",  0, F3_W,  32'h10, 0, 32'h8899AABB, 0, 2, 1, 0, 0, 0);

        // Byte store merge, then read back
        wr_q.push_back('{addr: 32'h10, data: 32'h8855AABB});
        do_op("sb", 1, F3_B, 32'h12, 32'h12345655, 32'h8899AABB, 0, 3, 1, 1, 0, 0);
        do_op("lw_after_sb", 0, F3_W, 32'h10, 0, 32'h8855AABB, 0, 2, 1, 0, 0, 0);
        last_r = 32'h8855AABB;

        // Rejected requests: one-cycle error, no memory traffic, rdata held
        do_op("err_sw_mis", 1, F3_W,   32'h16,   32'h1, last_r, 1, 1, 0, 0, 0, 0);
        do_op("err_lh_mis", 0, F3_H,   32'h11,   0,     last_r, 1, 1, 0, 0, 0, 0);
        do_op("err_f3_011", 0, 3'b011, 32'h10,   0,     last_r, 1, 1, 0, 0, 0, 0);
        do_op("err_range",  0, F3_W,   32'h4000, 0,     last_r, 1, 1, 0, 0, 0, 0);
        do_op("err_sbu",    1, F3_BU,  32'h10,   0,     last_r, 1, 1, 0, 0, 0, 0);

        // Word store, then load with req_i held high throughout
        wr_q.push_back('{addr: 32'h14, data: 32'hCAFEF00D});
        do_op("sw", 1, F3_W, 32'h14, 32'hCAFEF00D, last_r, 0, 2, 0, 1, 0, 0);
        do_op("lw_hold", 0, F3_W, 32'h14, 0, 32'hCAFEF00D, 0, 2, 1, 0, 1, 0);

        // Upper-half store with a stray req_i pulse while busy
        wr_q.push_back('{addr: 32'h14, data: 32'hBEEFF00D});
        do_op("sh_pulse", 1, F3_H, 32'h16, 32'h0000BEEF, 32'hCAFEF00D, 0, 3, 1, 1, 0, 1);
        do_op("lh_after_sh", 0, F3_H, 32'h16, 0, 32'hFFFFBEEF, 0, 2, 1, 0, 0, 0);

        // Reset landing in the WRITE cycle of an SH must not commit
        @(negedge clk);
        req_i = 1'b1; we_i = 1'b1; funct3_i = F3_H; addr_i = 32'h20; wdata_i = 32'h0000BEEF;
        @(posedge clk); #1;
        req_i = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check32("rstmid_wr_gated", {31'd0, mem_wr_en_o}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check32("rstmid_mem", mem[8], 32'h11223344);
        check32("rstmid_busy", {31'd0, busy_o}, 32'd0);
        check32("rstmid_done", {31'd0, done_o}, 32'd0);
        check32("rstmid_rdata", rdata_o, 32'd0);
        rst_n = 1'b1;
        do_op("lw_after_rst", 0, F3_W, 32'h20, 0, 32'h11223344, 0, 2, 1, 0, 0, 0);

        repeat (4) @(negedge clk);
        check32("exp_q_empty", 32'(exp_q.size()), 32'd0);
        check32("wr_q_empty", 32'(wr_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
